// File: rtl/switch_send_queue_if.sv
// switch_send_queue bus: core enqueue side, switch send side, status.
// The slave modport is the queue; master is the core/switch environment.
interface switch_send_queue_if #(
    parameter int SWITCH_WIDTH     = 16,
    parameter int SWITCH_CORE_SIZE = 8,
    parameter int DEPTH            = 4
);
    localparam int AW = $clog2(SWITCH_CORE_SIZE);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                         enq_valid;
    logic [AW-1:0]                enq_core_idx;
    logic [SWITCH_WIDTH-1:0][31:0] enq_data;
    logic                         enq_ready;

    logic                         switch_send_ready;
    logic [AW-1:0]                switch_send_core_idx;
    logic [SWITCH_WIDTH-1:0][31:0] switch_send_data;
    logic                         switch_send_ok;

    logic [CW-1:0]                count;
    logic                         idle;
    logic                         stall;

    modport slave (
        input  enq_valid, enq_core_idx, enq_data, switch_send_ok,
        output enq_ready, switch_send_ready, switch_send_core_idx,
        output switch_send_data, count, idle, stall
    );

    modport master (
        output enq_valid, enq_core_idx, enq_data, switch_send_ok,
        input  enq_ready, switch_send_ready, switch_send_core_idx,
        input  switch_send_data, count, idle, stall
    );
endinterface

// File: rtl/switch_send_queue.sv
// Per-core outbound FIFO of destination-tagged vectors toward one
// Switch send port, with occupancy, idle and sticky stall reporting.
module switch_send_queue #(
    parameter int SWITCH_WIDTH     = 16,
    parameter int SWITCH_CORE_SIZE = 8,
    parameter int DEPTH            = 4,
    parameter int STALL_LIMIT      = 1024
) (
    input logic clock,
    input logic reset,
    switch_send_queue_if.slave bus
);
    localparam int AW = $clog2(SWITCH_CORE_SIZE);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef struct packed {
        logic [AW-1:0]                 idx;
        logic [SWITCH_WIDTH-1:0][31:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [SW-1:0] wait_q;
    logic [SW-1:0] wait_d;
    logic          stall_q;
    logic          not_full;
    logic          not_empty;
    logic          push;
    logic          pop;

    assign not_full  = count_q < CW'(DEPTH);
    assign not_empty = count_q != '0;

    // Full refuses a push even when the same edge pops.
    assign push = bus.enq_valid && not_full;
    assign pop  = bus.switch_send_ok && not_empty;

    always_comb begin
        wait_d = wait_q;
        if (pop || !not_empty) begin
            wait_d = '0;
        end else if (wait_q != SW'(STALL_LIMIT)) begin
            wait_d = wait_q + SW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[wr_ptr] <= '{idx: bus.enq_core_idx, data: bus.enq_data};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            wait_q  <= wait_d;
            stall_q <= stall_q | (wait_d == SW'(STALL_LIMIT));
        end
    end

    assign bus.enq_ready            = not_full;
    assign bus.switch_send_ready    = not_empty;
    assign bus.switch_send_core_idx = mem[rd_ptr].idx;
    assign bus.switch_send_data     = mem[rd_ptr].data;
    assign bus.count                = count_q;
    assign bus.idle                 = !not_empty;
    assign bus.stall                = stall_q;
endmodule
